// File: rtl/core_irq_request_scheduler_pkg.sv
// Shared constants for the external IRQ request scheduler: FSM encodings and
// ICT priority levels.
package core_irq_request_scheduler_pkg;

  typedef enum logic [1:0] {
    STT_IDLE  = 2'h0,
    STT_OFFER = 2'h1
  } state_e;

  localparam int N_LVL = 4;

  localparam logic [1:0] LVL_0 = 2'd0;
  localparam logic [1:0] LVL_1 = 2'd1;
  localparam logic [1:0] LVL_2 = 2'd2;
  localparam logic [1:0] LVL_3 = 2'd3;

endpackage

// File: rtl/core_irq_request_scheduler_picker.sv
// Combinational winner selection: highest level with an eligible source, and
// round-robin from rr_ptr_i within that level.
module irq_priority_picker
  import core_irq_request_scheduler_pkg::*;
#(
  parameter int N_SRC = 64,
  parameter int IDW   = 6
) (
  input  logic [N_SRC-1:0]   elig_i,
  input  logic [2*N_SRC-1:0] level_i,
  input  logic [IDW-1:0]     rr_ptr_i,
  output logic               found_o,
  output logic [IDW-1:0]     idx_o
);

  logic           any_lvl [N_LVL];
  logic [IDW-1:0] enc_lvl [N_LVL];

  genvar gl, gi;
  generate
    for (gl = 0; gl < N_LVL; gl++) begin : g_lvl
      logic [N_SRC-1:0]   hit;
      logic [2*N_SRC-1:0] dbl;
      logic [N_SRC-1:0]   rot;
      logic [IDW-1:0]     enc;

      for (gi = 0; gi < N_SRC; gi++) begin : g_hit
        assign hit[gi] = elig_i[gi] && (level_i[2*gi +: 2] == 2'(gl));
      end

      // Rotating by rr_ptr puts the round-robin start at bit 0.
      assign dbl = {hit, hit} >> rr_ptr_i;
      assign rot = dbl[N_SRC-1:0];

      always_comb begin
        enc = '0;
        for (int j = N_SRC - 1; j >= 0; j--) begin
          if (rot[j]) enc = IDW'(j);
        end
      end

      assign any_lvl[gl] = |rot;
      assign enc_lvl[gl] = enc;
    end
  endgenerate

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int l = 0; l < N_LVL; l++) begin
      if (any_lvl[l]) begin
        found_o = 1'b1;
        idx_o   = enc_lvl[l] + rr_ptr_i;
      end
    end
  end

endmodule

// File: rtl/core_irq_request_scheduler.sv
// Latches external IRQ requests as pending bits and offers them one at a time
// to the core interrupt manager over the EXT_ACTIVE/EXT_NUM/EXT_ACK handshake.
module core_irq_request_scheduler
  import core_irq_request_scheduler_pkg::*;
#(
  parameter int N_SRC = 64,
  parameter int IDW   = 6
) (
  input  logic             iCLOCK,
  input  logic             inRESET,
  input  logic [N_SRC-1:0] iIRQ_REQ,
  input  logic             iICT_VALID,
  input  logic [IDW-1:0]   iICT_ENTRY,
  input  logic             iICT_CONF_MASK,
  input  logic             iICT_CONF_VALID,
  input  logic [1:0]       iICT_CONF_LEVEL,
  input  logic             iPEND_CLR_VALID,
  input  logic [IDW-1:0]   iPEND_CLR_NUM,
  output logic             oEXT_ACTIVE,
  output logic [IDW-1:0]   oEXT_NUM,
  input  logic             iEXT_ACK,
  output logic [N_SRC-1:0] oPENDING
);

  state_e             state_q, state_d;
  logic [N_SRC-1:0]   pending_q, pending_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]     last_num_q, last_num_d;

  logic [N_SRC-1:0]   ict_mask_q;
  logic [N_SRC-1:0]   ict_valid_q;
  logic [1:0]         ict_level_q [N_SRC];

  logic [N_SRC-1:0]   eligible;
  logic [2*N_SRC-1:0] eff_level;
  logic               pick_found;
  logic [IDW-1:0]     pick_idx;
  logic               ack_fire;
  logic               withdraw;

  assign ack_fire = (state_q == STT_OFFER) && iEXT_ACK;
  // A software clear of the offered source withdraws it unless re-requested now.
  assign withdraw = (state_q == STT_OFFER) && !iEXT_ACK && iPEND_CLR_VALID &&
                    (iPEND_CLR_NUM == last_num_q) && !iIRQ_REQ[last_num_q];

  genvar gi;
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_src
      assign eligible[gi] = pending_q[gi] && (!ict_valid_q[gi] || ict_mask_q[gi]);
      assign eff_level[2*gi +: 2] = ict_valid_q[gi] ? ict_level_q[gi] : LVL_0;

      always_comb begin
        pending_d[gi] = pending_q[gi];
        if (iIRQ_REQ[gi]) begin
          pending_d[gi] = 1'b1;
        end else if ((ack_fire && (last_num_q == IDW'(gi))) ||
                     (iPEND_CLR_VALID && (iPEND_CLR_NUM == IDW'(gi)))) begin
          pending_d[gi] = 1'b0;
        end
      end
    end
  endgenerate

  irq_priority_picker #(
    .N_SRC (N_SRC),
    .IDW   (IDW)
  ) u_picker (
    .elig_i   (eligible),
    .level_i  (eff_level),
    .rr_ptr_i (rr_ptr_q),
    .found_o  (pick_found),
    .idx_o    (pick_idx)
  );

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state_q    <= STT_IDLE;
      pending_q  <= '0;
      rr_ptr_q   <= '0;
      last_num_q <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      rr_ptr_q   <= rr_ptr_d;
      last_num_q <= last_num_d;
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      ict_mask_q  <= '0;
      ict_valid_q <= '0;
      for (int i = 0; i < N_SRC; i++) ict_level_q[i] <= LVL_0;
    end else if (iICT_VALID) begin
      ict_mask_q[iICT_ENTRY]  <= iICT_CONF_MASK;
      ict_valid_q[iICT_ENTRY] <= iICT_CONF_VALID;
      ict_level_q[iICT_ENTRY] <= iICT_CONF_LEVEL;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      STT_IDLE:  if (pick_found) state_d = STT_OFFER;
      STT_OFFER: if (iEXT_ACK || withdraw) state_d = STT_IDLE;
      default:   state_d = STT_IDLE;
    endcase
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    last_num_d = last_num_q;
    if (state_q == STT_IDLE && pick_found) last_num_d = pick_idx;
    if (ack_fire) rr_ptr_d = last_num_q + IDW'(1);
  end

  always_comb begin
    oEXT_ACTIVE = 1'b0;
    oEXT_NUM    = '0;
    if (state_q == STT_OFFER) begin
      oEXT_ACTIVE = 1'b1;
      oEXT_NUM    = last_num_q;
    end
  end

  assign oPENDING = pending_q;

endmodule
